// File: rtl/clint_bus_arb_pkg.sv
`default_nettype none
//==============================================================================
// Module   : clint_bus_arb_pkg
// Brief    : Shared CLINT defines: XLEN, register map, arbiter master IDs and
//            lock FSM state encodings.
// Revision : 1.0 - initial release
//==============================================================================
package clint_bus_arb_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] CLINT_BASE       = 32'h0200_0000;
    localparam logic [XLEN-1:0] CLINT_MSIP       = CLINT_BASE + 32'h0000_0000;
    localparam logic [XLEN-1:0] CLINT_MTIMECMP_L = CLINT_BASE + 32'h0000_4000;
    localparam logic [XLEN-1:0] CLINT_MTIMECMP_H = CLINT_BASE + 32'h0000_4004;
    localparam logic [XLEN-1:0] CLINT_MTIME_L    = CLINT_BASE + 32'h0000_BFF8;
    localparam logic [XLEN-1:0] CLINT_MTIME_H    = CLINT_BASE + 32'h0000_BFFC;

    localparam logic ARB_M0 = 1'b0;
    localparam logic ARB_M1 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } lock_state_e;

endpackage
`default_nettype wire

// File: rtl/clint_bus_arb_rr_arb2.sv
`default_nettype none
//==============================================================================
// Module   : rr_arb2
// Brief    : Two-way round-robin picker holding the last-grant register.
// Revision : 1.0 - initial release
//==============================================================================
module rr_arb2
    import clint_bus_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    logic r_last;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (r_last == ARB_M1) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Reset to M1 so that M0 wins the very first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= ARB_M1;
        end else if (update && (grant != 2'b00)) begin
            r_last <= grant[1] ? ARB_M1 : ARB_M0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/clint_bus_arb.sv
`default_nettype none
//==============================================================================
// Module   : clint_bus_arb
// Brief    : Two-master arbiter onto the CLINT split read/write register port.
//            Optional master lock for atomic L/H pairs: CLINT_ARB_LOCK_EN.
// Revision : 1.0 - initial release
//==============================================================================
module clint_bus_arb
    import clint_bus_arb_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int LOCK_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic [3:0]    m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic          m0_lock,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic [3:0]    m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic          m1_lock,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          s_ena,
    output logic [AW-1:0] s_addra,
    output logic [3:0]    s_wea,
    output logic [DW-1:0] s_dina,
    output logic          s_enb,
    output logic [AW-1:0] s_addrb,
    input  logic [DW-1:0] s_doutb,
    output logic          lock_err
);

    logic [1:0]    w_block;
    logic [1:0]    w_grant;
    logic          w_xfer;
    logic          w_sel;
    logic [3:0]    w_we;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;
    logic          w_is_rd;
    logic          r_rvalid;
    logic          r_owner;

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .rst    (rst),
        .req    ({m1_req & ~w_block[1], m0_req & ~w_block[0]}),
        .update (w_xfer),
        .grant  (w_grant)
    );

    assign m0_gnt = w_grant[0];
    assign m1_gnt = w_grant[1];
    assign w_xfer = |w_grant;

    // With no grant w_sel is 0, so idle address/data follow master 0.
    assign w_sel   = w_grant[1];
    assign w_we    = w_sel ? m1_we    : m0_we;
    assign w_addr  = w_sel ? m1_addr  : m0_addr;
    assign w_wdata = w_sel ? m1_wdata : m0_wdata;
    assign w_is_rd = w_xfer && (w_we == 4'b0000);

    assign s_ena   = w_xfer && (w_we != 4'b0000);
    assign s_wea   = s_ena ? w_we : 4'b0000;
    assign s_addra = w_addr;
    assign s_dina  = w_wdata;
    assign s_enb   = w_is_rd;
    assign s_addrb = w_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rvalid <= 1'b0;
            r_owner  <= ARB_M0;
        end else begin
            r_rvalid <= w_is_rd;
            if (w_is_rd) begin
                r_owner <= w_sel;
            end
        end
    end

    assign m0_rvalid = r_rvalid && (r_owner == ARB_M0);
    assign m1_rvalid = r_rvalid && (r_owner == ARB_M1);
    assign m0_rdata  = m0_rvalid ? s_doutb : '0;
    assign m1_rdata  = m1_rvalid ? s_doutb : '0;

`ifdef CLINT_ARB_LOCK_EN
    localparam int C_CNT_W = $clog2(LOCK_MAX + 1);

    lock_state_e          r_state;
    lock_state_e          w_state_nxt;
    logic [C_CNT_W-1:0]   r_cnt;
    logic [C_CNT_W-1:0]   w_cnt_nxt;
    logic                 r_lock_err;
    logic                 w_lock_err_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_lock_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_lock_err <= w_lock_err_nxt;
        end
    end

    // The forced release fires on the cycle the count would reach LOCK_MAX,
    // so the other master is held off for exactly LOCK_MAX cycles.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_lock_err_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant[0] && m0_lock) begin
                    w_state_nxt = ST_LOCK0;
                    w_cnt_nxt   = '0;
                end else if (w_grant[1] && m1_lock) begin
                    w_state_nxt = ST_LOCK1;
                    w_cnt_nxt   = '0;
                end
            end
            ST_LOCK0, ST_LOCK1: begin
                if ((r_state == ST_LOCK0) ? (w_grant[0] && !m0_lock)
                                          : (w_grant[1] && !m1_lock)) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == C_CNT_W'(LOCK_MAX - 1)) begin
                    w_state_nxt    = ST_IDLE;
                    w_cnt_nxt      = '0;
                    w_lock_err_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_block  = {r_state == ST_LOCK0, r_state == ST_LOCK1};
    assign lock_err = r_lock_err;
`else
    logic w_unused;

    assign w_unused = &{1'b0, m0_lock, m1_lock, (LOCK_MAX > 0)};
    assign w_block  = 2'b00;
    assign lock_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clint_bus_arb.sv
`default_nettype none
//==============================================================================
// Module   : tb_clint_bus_arb
// Brief    : Scoreboard bench for clint_bus_arb with directed vectors.
// Revision : 1.0 - initial release
//==============================================================================
module tb_clint_bus_arb;
    import clint_bus_arb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          m0_req = 1'b0, m1_req = 1'b0;
    logic [3:0]    m0_we = 4'h0, m1_we = 4'h0;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
    logic          m0_lock = 1'b0, m1_lock = 1'b0;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          s_ena, s_enb, lock_err;
    logic [AW-1:0] s_addra, s_addrb;
    logic [3:0]    s_wea;
    logic [DW-1:0] s_dina;
    logic [DW-1:0] s_doutb;

    int checks = 0;
    int errors = 0;

    typedef struct packed {logic owner; logic [DW-1:0] data;} rd_t;
    typedef struct packed {logic [AW-1:0] addr; logic [3:0] wea; logic [DW-1:0] data;} wr_t;
    rd_t rd_q[$];
    wr_t wr_q[$];

    always #5 clk = ~clk;

    clint_bus_arb #(.AW(AW), .DW(DW), .LOCK_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_lock(m0_lock), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .s_ena(s_ena), .s_addra(s_addra), .s_wea(s_wea), .s_dina(s_dina),
        .s_enb(s_enb), .s_addrb(s_addrb), .s_doutb(s_doutb), .lock_err(lock_err)
    );

    // CLINT read port model: fixed contents, one-cycle registered read.
    function automatic logic [DW-1:0] slave_data(input logic [AW-1:0] a);
        if (a == CLINT_MTIME_L) return 32'h0000_1234;
        if (a == CLINT_MTIME_H) return 32'h0000_5678;
        return a ^ 32'hFFFF_0000;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        s_doutb <= '0;
        else if (s_enb) s_doutb <= slave_data(s_addrb);
    end

    function automatic void chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: pops expected responses whenever the DUT presents one.
    always @(negedge clk) begin
        if (m0_rvalid && m1_rvalid) chk("rvalid_both", 1, 0);
        else if (m0_rvalid || m1_rvalid) begin
            if (rd_q.size() == 0) chk("rvalid_unexpected", {m1_rvalid, m0_rvalid}, 0);
            else begin
                rd_t e;
                e = rd_q.pop_front();
                chk("rd_owner", m1_rvalid, e.owner);
                chk("rd_data", m1_rvalid ? m1_rdata : m0_rdata, e.data);
                chk("rd_other_zero", m1_rvalid ? m0_rdata : m1_rdata, 0);
            end
        end
        if (s_ena) begin
            if (wr_q.size() == 0) chk("s_ena_unexpected", s_ena, 0);
            else begin
                wr_t w;
                w = wr_q.pop_front();
                chk("wr_port", {s_addra, s_wea, s_dina}, {w.addr, w.wea, w.data});
            end
        end
    end

    task automatic drive(input int m, input logic req, input logic [3:0] we,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input logic lock = 1'b0);
        if (m == 0) begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wd; m0_lock = lock;
        end else begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wd; m1_lock = lock;
        end
    endtask

    // One bus cycle: push expectation, check grant/port at negedge, advance.
    task automatic step(input logic [1:0] exp_g, input logic [DW-1:0] exp_rd = '0,
                        input logic exp_lerr = 1'b0, input bit push = 1'b1);
        logic          sel;
        logic [3:0]    we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        sel  = exp_g[1];
        we   = sel ? m1_we : m0_we;
        addr = sel ? m1_addr : m0_addr;
        wd   = sel ? m1_wdata : m0_wdata;
        if (exp_g != 2'b00 && push) begin
            if (we == 4'h0) rd_q.push_back('{owner: sel, data: exp_rd});
            else            wr_q.push_back('{addr: addr, wea: we, data: wd});
        end
        @(negedge clk);
        chk("gnt", {m1_gnt, m0_gnt}, exp_g);
        chk("lock_err", lock_err, exp_lerr);
        if (exp_g != 2'b00 && we == 4'h0) begin
            chk("rd_enables", {s_ena, s_enb}, 2'b01);
            chk("s_addrb", s_addrb, addr);
        end else if (exp_g != 2'b00) begin
            chk("wr_enb", s_enb, 0);
        end else begin
            chk("idle_en", {s_ena, s_enb, s_wea}, 0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_flags", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, lock_err, s_ena, s_enb, s_wea}, 0);
        chk("reset_rdata", {m0_rdata, m1_rdata}, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Lone m0 read of MTIME_L.
        drive(0, 1, 4'h0, CLINT_MTIME_L, '0);
        step(2'b01, 32'h0000_1234);
        drive(0, 0, 4'h0, '0, '0);
        step(2'b00);

        // Lone m1 partial write; no response follows.
        drive(1, 1, 4'b0011, CLINT_MTIMECMP_H, 32'h0000_ABCD);
        step(2'b10);
        drive(1, 0, 4'h0, '0, '0);
        step(2'b00);

        // Contention: grants alternate m0, m1, m0, m1.
        drive(0, 1, 4'hF, CLINT_MSIP, 32'hA0);
        drive(1, 1, 4'hF, CLINT_MTIMECMP_L, 32'hB0);
        step(2'b01);
        drive(0, 1, 4'hF, CLINT_MSIP, 32'hA1);
        step(2'b10);
        drive(1, 1, 4'hF, CLINT_MTIMECMP_L, 32'hB1);
        step(2'b01);
        drive(0, 1, 4'hF, CLINT_MSIP, 32'hA2);
        step(2'b10);
        drive(0, 0, 4'h0, '0, '0);
        drive(1, 0, 4'h0, '0, '0);
        step(2'b00);

        // Read then write back-to-back, then two pipelined reads.
        drive(0, 1, 4'h0, CLINT_MTIME_H, '0);
        step(2'b01, 32'h0000_5678);
        drive(0, 0, 4'h0, '0, '0);
        drive(1, 1, 4'hF, CLINT_MTIMECMP_L, 32'h55);
        step(2'b10);
        drive(1, 1, 4'h0, CLINT_MSIP, '0);
        step(2'b10, 32'hFDFF_0000);
        drive(1, 0, 4'h0, '0, '0);
        drive(0, 1, 4'h0, CLINT_MTIME_L, '0);
        step(2'b01, 32'h0000_1234);
        drive(0, 0, 4'h0, '0, '0);
        step(2'b00);

        // Make m1 the last grantee so m0 wins the next contention.
        drive(1, 1, 4'hF, CLINT_MSIP, 32'h1);
        step(2'b10);

`ifdef CLINT_ARB_LOCK_EN
        drive(0, 1, 4'hF, CLINT_MTIMECMP_L, 32'h1111, 1'b1);
        drive(1, 1, 4'hF, CLINT_MSIP, 32'h2);
        step(2'b01);
        drive(0, 1, 4'hF, CLINT_MTIMECMP_H, 32'h2222, 1'b0);
        step(2'b01);
        drive(0, 0, 4'h0, '0, '0);
        step(2'b10);
        drive(1, 0, 4'h0, '0, '0);
        step(2'b00);

        drive(0, 1, 4'hF, CLINT_MTIMECMP_L, 32'h3333, 1'b1);
        step(2'b01);
        drive(0, 0, 4'h0, '0, '0);
        drive(1, 1, 4'hF, CLINT_MSIP, 32'h3);
        repeat (4) step(2'b00);
        step(2'b10, '0, 1'b1);
        drive(1, 0, 4'h0, '0, '0);
        step(2'b00);
`else
        drive(0, 1, 4'hF, CLINT_MTIMECMP_L, 32'h1111, 1'b1);
        drive(1, 1, 4'hF, CLINT_MSIP, 32'h2);
        step(2'b01);
        drive(0, 1, 4'hF, CLINT_MTIMECMP_H, 32'h2222, 1'b1);
        step(2'b10);
        drive(1, 0, 4'h0, '0, '0);
        step(2'b01);
        drive(0, 0, 4'h0, '0, '0);
        step(2'b00);
`endif

        // Reset the cycle after a granted read: response must vanish.
        drive(1, 0, 4'h0, '0, '0);
        drive(0, 1, 4'h0, CLINT_MTIME_L, '0);
        step(2'b01, '0, 1'b0, 1'b0);
        rst = 1'b1;
        drive(0, 0, 4'h0, '0, '0);
        @(negedge clk);
        chk("rst_mid_rvalid", {m0_rvalid, m1_rvalid}, 0);
        chk("rst_mid_rdata", {m0_rdata, m1_rdata}, 0);
        chk("rst_mid_gnt", {m0_gnt, m1_gnt, lock_err}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        step(2'b00);
        drive(1, 1, 4'h0, CLINT_MSIP, '0);
        step(2'b10, 32'hFDFF_0000);
        drive(1, 0, 4'h0, '0, '0);
        step(2'b00);
        step(2'b00);

        chk("rd_q_drained", rd_q.size(), 0);
        chk("wr_q_drained", wr_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clint_bus_arb.md
Name: clint_bus_arb

Overview:
- Two-master arbiter that shares the single CLINT register port between the core load/store unit (master 0) and the debug/DMA requester (master 1).
- Converts per-master req/gnt transactions into the CLINT's split write (ena/addra/wea/dina) and read (enb/addrb/doutb) ports.
- Routes each 1-cycle-latency read response back to the master that issued it.
- Sits between the core/debug bus decode and the clint instance.

Parameters:
- AW, 32, address width (matches XLEN).
- DW, 32, data width (matches XLEN).
- LOCK_MAX, 4, maximum cycles a lock may be held before forced release (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- m0_req / m1_req  in  1  transaction request.
- m0_we / m1_we  in  4  byte write strobes; 0 means read.
- m0_addr / m1_addr  in  AW  address.
- m0_wdata / m1_wdata  in  DW  write data.
- m0_lock / m1_lock  in  1  hold ownership after this transfer (optional feature).
- m0_gnt / m1_gnt  out  1  request accepted this cycle (combinational).
- m0_rvalid / m1_rvalid  out  1  read data valid.
- m0_rdata / m1_rdata  out  DW  read data.
- s_ena  out  1  CLINT write enable.
- s_addra  out  AW  CLINT write address.
- s_wea  out  4  CLINT byte strobes.
- s_dina  out  DW  CLINT write data.
- s_enb  out  1  CLINT read enable.
- s_addrb  out  AW  CLINT read address.
- s_doutb  in  DW  CLINT read data, registered, valid 1 cycle after s_enb.
- lock_err  out  1  one-cycle pulse on forced lock release.

Behaviour:
- Reset values:
  - gnt, rvalid and lock_err are 0; rdata is 0.
  - Last-grant register is 1, so m0 wins the first contention.
  - Lock FSM is in IDLE; lock counter is 0.
- Handshake:
  - A transfer completes in the cycle where req=1 and gnt=1.
  - The master must hold addr/we/wdata stable while req=1 and gnt=0.
  - At most one gnt per cycle.
  - Back-to-back grants are allowed: one transfer per cycle, fully pipelined.
- Arbitration:
  - Only one master requesting: it is granted.
  - Both requesting: the master not granted last is granted (round-robin).
  - The last-grant register updates only on a completed transfer.
- Slave drive:
  - Granted write (we≠0): s_ena=1, s_wea=we, s_addra=addr, s_dina=wdata, s_enb=0, in the same cycle.
  - Granted read (we=0): s_enb=1, s_addrb=addr, s_ena=0.
  - No grant: s_ena=0, s_enb=0, s_wea=0. Address and data outputs are don't-care and are driven from master 0's signals.
- Response:
  - A registered valid bit and owner bit are captured on a granted read.
  - The next cycle, rvalid of that owner is 1 and its rdata = s_doutb; the other master sees rvalid=0 and rdata=0.
  - Writes produce no response.
  - A read granted in cycle N and a write granted in cycle N+1 are independent.
- Reset mid-transfer: the pending response is discarded, with no rvalid after reset deassertion.
- Width rules: no address translation; addresses pass straight through to the CLINT.

Optional Feature:
- Macro CLINT_ARB_LOCK_EN.
- With the macro defined, the lock FSM has states IDLE, LOCK0 and LOCK1:
  - IDLE→LOCKn when master n completes a transfer with lock=1.
  - In LOCKn the other master's gnt is forced to 0 and the counter increments each cycle.
  - LOCKn→IDLE when master n completes a transfer with lock=0.
  - LOCKn→IDLE when the counter reaches LOCK_MAX: lock_err pulses for 1 cycle and the counter clears.
  - Entering LOCKn clears the counter.
  - Use case: atomic 64-bit mtime/mtimecmp L+H accesses.
- Without the macro:
  - Lock inputs are ignored and lock_err is tied to 0.
  - Arbitration is pure round-robin with no FSM.

Decomposition:
- The shared defines file gains the master ID constants (ARB_M0=0, ARB_M1=1) and the lock state encodings.
- XLEN and the CLINT address macros already live there.
- One sub-module: rr_arb2, a 2-way round-robin picker (req[1:0], update, grant[1:0]) holding the last-grant register.

Test Plan:
- m0 read of MTIME_L alone, s_doutb=0x0000_1234 → cycle 0: m0_gnt=1, s_enb=1, s_addrb=MTIME_L; cycle 1: m0_rvalid=1, m0_rdata=0x0000_1234, m1_rvalid=0.
- Both request every cycle for 4 cycles → grants alternate m0,m1,m0,m1; each write appears on s_ena/s_wea in the granting cycle.
- m1 write wea=4'b0011 to MTIMECMP_H, data 0xABCD → s_ena=1, s_wea=0011, s_dina=0xABCD same cycle; no rvalid follows.
- LOCK_EN: m0 writes MTIMECMP_L with lock=1, then MTIMECMP_H with lock=0, while m1 requests continuously → m1_gnt=0 until the cycle after m0's second transfer.
- LOCK_EN, LOCK_MAX=4: m0 locks then idles → m1 is granted after 4 cycles, with a single lock_err pulse.
- rst asserted the cycle after a granted read → no rvalid on either master; all outputs return to reset values immediately.
